// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
package rf_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      logic                valid;
      reg_addr_t           rd;
      logic [XLEN_DEF-1:0] data;
   } wb_req_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
      return NUM_REGS'(1) << a;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from the valid vector and an
// internal rotating pointer that moves one past each winner.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N-1:0]                        valid,
   output logic [N-1:0]                        grant,
   output logic [(N > 1 ? $clog2(N) : 1)-1:0]  grant_idx,
   output logic                                grant_any
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] rr_ptr_q;
   logic [IW-1:0] rr_ptr_d;
   logic [IW-1:0] cand;
   logic [IW-1:0] idx_c;
   logic          found;

   // Scan starting at the pointer, wrapping modulo N.
   always_comb begin
      cand  = '0;
      idx_c = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(rr_ptr_q) + k) % N);
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx_c = cand;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (found) begin
         if (idx_c == IW'(N - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = idx_c + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign grant     = found ? (N'(1) << idx_c) : '0;
   assign grant_idx = idx_c;
   assign grant_any = found;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with optional RAW scoreboard.
// Scoreboard storage is built only when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = XLEN_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_rd,
   input  logic [NUM_REQ-1:0][XLEN-1:0]         req_data,
   output logic                                 rf_we,
   output logic [REG_ADDR_W-1:0]                rf_waddr,
   output logic [XLEN-1:0]                      rf_wdata,
   input  logic                                 issue_valid,
   input  logic [REG_ADDR_W-1:0]                issue_rd,
   input  logic                                 flush,
   output logic [NUM_REGS-1:0]                  busy_mask,
   output logic                                 sb_err
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_any;
   reg_addr_t          win_rd;
   logic [XLEN-1:0]    win_data;

   logic               rf_we_q,    rf_we_d;
   reg_addr_t          rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (req_valid),
      .grant     (grant),
      .grant_idx (gnt_idx),
      .grant_any (gnt_any)
   );

   assign req_ready = grant;
   assign win_rd    = req_rd[gnt_idx];
   assign win_data  = req_data[gnt_idx];

   // x0 writebacks are consumed but never reach the write port.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (gnt_any) begin
         rf_we_d    = (win_rd != '0);
         rf_waddr_d = win_rd;
         rf_wdata_d = win_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_SCOREBOARD_EN
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] set_vec;
   logic                sb_err_q, sb_err_d;

   assign clr_vec = rf_we_q ? reg_onehot(rf_waddr_q) : '0;
   assign set_vec = (issue_valid && issue_rd != '0) ?
                    reg_onehot(issue_rd) : '0;

   // Set is applied after clear/flush so a same-cycle issue survives.
   always_comb begin
      if (flush) begin
         busy_d = set_vec;
      end else begin
         busy_d = (busy_q & ~clr_vec) | set_vec;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      sb_err_d = sb_err_q;
      if (issue_valid && !flush && busy_q[issue_rd]) begin
         sb_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= '0;
         sb_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         sb_err_q <= sb_err_d;
      end
   end

   // The register file forwards the in-flight write to same-cycle reads.
   assign busy_mask = busy_q & ~clr_vec;
   assign sb_err    = sb_err_q;
`else
   logic unused_sb;
   assign unused_sb = ^{issue_valid, issue_rd, flush};
   assign busy_mask = '0;
   assign sb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench for rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int N  = 3;
   localparam int XW = 32;
`ifdef RF_WB_SCOREBOARD_EN
   localparam bit SB_ON = 1'b1;
`else
   localparam bit SB_ON = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N-1:0][4:0]    req_rd;
   logic [N-1:0][XW-1:0] req_data;
   logic                 rf_we;
   logic [4:0]           rf_waddr;
   logic [XW-1:0]        rf_wdata;
   logic                 issue_valid;
   logic [4:0]           issue_rd;
   logic                 flush;
   logic [31:0]          busy_mask;
   logic                 sb_err;

   rf_wb_arbiter #(
      .NUM_REQ (N),
      .XLEN    (XW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .flush       (flush),
      .busy_mask   (busy_mask),
      .sb_err      (sb_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: what the write port and scoreboard must hold now.
   int          m_ptr;
   bit          m_we;
   bit [4:0]    m_waddr;
   bit [XW-1:0] m_wdata;
   bit [31:0]   m_busy;
   bit          m_err;
   bit [N-1:0]  granted_last;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_busy  = '0;
      m_err   = 1'b0;
   endtask

   // Called at the falling edge: compare, then advance the model.
   task automatic sample();
      int          g;
      bit [N-1:0]  er;
      bit [31:0]   em;
      @(negedge clk);
      if (rst) model_reset();
      g = -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (g < 0 && req_valid[i]) g = i;
      end
      er = (g >= 0) ? (N'(1) << g) : '0;
      em = SB_ON ? (m_busy & ~(m_we ? (32'd1 << m_waddr) : 32'd0)) : 32'd0;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rf_we",     64'(rf_we),     64'(m_we));
      chk("rf_waddr",  64'(rf_waddr),  64'(m_waddr));
      chk("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
      chk("busy_mask", 64'(busy_mask), 64'(em));
      chk("sb_err",    64'(sb_err),    64'(m_err));
      if (rst) begin
         granted_last = '0;
      end else begin
         if (SB_ON) begin
            if (issue_valid && !flush && issue_rd != 0 && m_busy[issue_rd])
               m_err = 1'b1;
            if (flush) m_busy = '0;
            else if (m_we) m_busy[m_waddr] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
         end
         if (g >= 0) begin
            m_we    = (req_rd[g] != 0);
            m_waddr = req_rd[g];
            m_wdata = req_data[g];
            m_ptr   = (g + 1) % N;
         end else begin
            m_we = 1'b0;
         end
         granted_last = er;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_random();
      for (int i = 0; i < N; i++) begin
         if (!(req_valid[i] && !granted_last[i])) begin
            req_valid[i] = ($urandom_range(0, 99) < 55);
            req_rd[i]    = 5'($urandom_range(0, 15));
            req_data[i]  = $urandom;
         end
      end
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd    = 5'($urandom_range(0, 15));
      flush       = ($urandom_range(0, 99) < 4);
      rst         = ($urandom_range(0, 299) == 0);
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = '0;
      req_rd      = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      flush       = 1'b0;
      granted_last = '0;
      model_reset();
      adv();
      sample();
      adv();

      // Round-robin with all three requesters held valid.
      rst       = 1'b0;
      req_valid = 3'b111;
      req_rd[0] = 5'd5; req_data[0] = 32'h100;
      req_rd[1] = 5'd6; req_data[1] = 32'h200;
      req_rd[2] = 5'd7; req_data[2] = 32'h300;
      sample(); chk("rr_g0", 64'(req_ready), 64'(3'b001)); adv();
      sample(); chk("rr_g1", 64'(req_ready), 64'(3'b010));
      chk("rr_a5", 64'(rf_waddr), 64'd5); adv();
      sample(); chk("rr_g2", 64'(req_ready), 64'(3'b100));
      chk("rr_a6", 64'(rf_waddr), 64'd6); adv();
      sample(); chk("rr_g3", 64'(req_ready), 64'(3'b001));
      chk("rr_a7", 64'(rf_waddr), 64'd7); adv();
      sample(); chk("rr_a5b", 64'(rf_waddr), 64'd5); adv();

      // Reset in the middle of traffic.
      rst = 1'b1;
      sample();
      chk("rst_we",   64'(rf_we),     64'd0);
      chk("rst_busy", 64'(busy_mask), 64'd0);
      chk("rst_err",  64'(sb_err),    64'd0);
      adv();
      rst = 1'b0;
      sample(); chk("rst_first", 64'(req_ready), 64'(3'b001)); adv();
      sample(); chk("rst_first_a", 64'(rf_waddr), 64'd5);
      chk("rst_first_we", 64'(rf_we), 64'd1); adv();

      // Write to x0 is consumed with no register-file write.
      req_valid   = 3'b001;
      req_rd[0]   = 5'd0;
      req_data[0] = 32'hDEADBEEF;
      sample(); chk("x0_ready", 64'(req_ready), 64'(3'b001)); adv();
      req_valid = '0;
      sample(); chk("x0_we", 64'(rf_we), 64'd0); adv();

      // Scoreboard set, clear on write, re-issue in the write cycle.
      issue_valid = 1'b1; issue_rd = 5'd10;
      sample(); adv();
      issue_valid = 1'b0;
      req_valid   = 3'b010; req_rd[1] = 5'd10; req_data[1] = 32'h0000A5A5;
      sample(); chk("sb_set10", 64'(busy_mask[10]), 64'(SB_ON)); adv();
      req_valid   = '0;
      issue_valid = 1'b1; issue_rd = 5'd10;
      sample();
      chk("sb_wr_we",  64'(rf_we),         64'd1);
      chk("sb_wr_a",   64'(rf_waddr),      64'd10);
      chk("sb_clr10",  64'(busy_mask[10]), 64'd0);
      adv();
      issue_valid = 1'b0;
      sample(); chk("sb_reset10", 64'(busy_mask[10]), 64'(SB_ON)); adv();

      // Flush coinciding with an issue leaves only the issued register.
      issue_valid = 1'b1; issue_rd = 5'd3;
      sample(); adv();
      issue_rd = 5'd4;
      sample(); adv();
      issue_rd = 5'd9; flush = 1'b1;
      sample(); adv();
      issue_valid = 1'b0; flush = 1'b0;
      sample();
      chk("flush_mask", 64'(busy_mask), SB_ON ? 64'h200 : 64'h0);
      adv();

      // Sticky error on double issue, cleared only by reset.
      rst = 1'b1; sample(); adv(); rst = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd12;
      sample(); adv();
      sample(); adv();
      issue_valid = 1'b0;
      sample(); chk("err_set", 64'(sb_err), 64'(SB_ON)); adv();
      for (int c = 0; c < 4; c++) begin
         sample(); adv();
      end
      sample(); chk("err_sticky", 64'(sb_err), 64'(SB_ON)); adv();
      rst = 1'b1;
      sample(); chk("err_rst", 64'(sb_err), 64'd0); adv();
      rst = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         drive_random();
         sample();
         adv();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
